// File: rtl/arcade_input_pkg.sv
// rtl/arcade_input_pkg.sv - shared constants, key map and coin FSM types for the input hub
//
// Purpose : button bit positions, PS/2 scan codes per player, coin stretcher
//           state enum and the scan-code decoder used by arcade_input_hub.
// Ports   : none (package).
package arcade_input_pkg;

   localparam int PLAYERS_MAX = 4;

   // Button bit positions inside each player's 8-bit vector
   localparam int BTN_R     = 0;
   localparam int BTN_L     = 1;
   localparam int BTN_D     = 2;
   localparam int BTN_U     = 3;
   localparam int BTN_F1    = 4;
   localparam int BTN_F2    = 5;
   localparam int BTN_START = 6;
   localparam int BTN_COIN  = 7;

   // Player 0 (arrows match with or without the extended prefix)
   localparam logic [8:0] KEY_P0_U    = 9'h075;
   localparam logic [8:0] KEY_P0_D    = 9'h072;
   localparam logic [8:0] KEY_P0_L    = 9'h06B;
   localparam logic [8:0] KEY_P0_R    = 9'h074;
   localparam logic [8:0] KEY_P0_F1A  = 9'h029;
   localparam logic [8:0] KEY_P0_F1B  = 9'h014;
   localparam logic [8:0] KEY_P0_F2   = 9'h011;
   localparam logic [8:0] KEY_P0_STA  = 9'h016;
   localparam logic [8:0] KEY_P0_STB  = 9'h005;
   localparam logic [8:0] KEY_P0_COIN = 9'h02E;

   // Player 1
   localparam logic [8:0] KEY_P1_U    = 9'h02D;
   localparam logic [8:0] KEY_P1_D    = 9'h02B;
   localparam logic [8:0] KEY_P1_L    = 9'h023;
   localparam logic [8:0] KEY_P1_R    = 9'h034;
   localparam logic [8:0] KEY_P1_F1   = 9'h01C;
   localparam logic [8:0] KEY_P1_F2   = 9'h01B;
   localparam logic [8:0] KEY_P1_STA  = 9'h01E;
   localparam logic [8:0] KEY_P1_STB  = 9'h006;
   localparam logic [8:0] KEY_P1_COIN = 9'h036;

   // Player 2
   localparam logic [8:0] KEY_P2_U    = 9'h043;
   localparam logic [8:0] KEY_P2_D    = 9'h042;
   localparam logic [8:0] KEY_P2_L    = 9'h03B;
   localparam logic [8:0] KEY_P2_R    = 9'h04B;
   localparam logic [8:0] KEY_P2_F1   = 9'h03A;
   localparam logic [8:0] KEY_P2_F2   = 9'h031;
   localparam logic [8:0] KEY_P2_ST   = 9'h026;
   localparam logic [8:0] KEY_P2_COIN = 9'h03D;

   // Player 3
   localparam logic [8:0] KEY_P3_U    = 9'h044;
   localparam logic [8:0] KEY_P3_D    = 9'h04D;
   localparam logic [8:0] KEY_P3_L    = 9'h054;
   localparam logic [8:0] KEY_P3_R    = 9'h05B;
   localparam logic [8:0] KEY_P3_F1   = 9'h049;
   localparam logic [8:0] KEY_P3_F2   = 9'h041;
   localparam logic [8:0] KEY_P3_ST   = 9'h025;
   localparam logic [8:0] KEY_P3_COIN = 9'h03E;

   // Service / test key
   localparam logic [8:0] KEY_TEST    = 9'h02C;

   typedef enum logic [1:0] {
      COIN_IDLE     = 2'd0,
      COIN_HOLD     = 2'd1,
      COIN_WAIT_REL = 2'd2
   } coin_state_e;

   typedef struct packed {
      logic       hit;      // code maps to a player button
      logic [1:0] player;
      logic [2:0] bit_idx;
      logic       test;     // code is the test key
   } key_hit_t;

   function automatic key_hit_t key_hit(input logic [1:0] player, input int bit_idx);
      key_hit_t h;
      h.hit     = 1'b1;
      h.player  = player;
      h.bit_idx = 3'(bit_idx);
      h.test    = 1'b0;
      return h;
   endfunction

   function automatic key_hit_t key_decode(input logic [8:0] code);
      key_hit_t h;
      h = '0;
      case (code)
         KEY_P0_F1A, KEY_P0_F1B: h = key_hit(2'd0, BTN_F1);
         KEY_P0_F2:              h = key_hit(2'd0, BTN_F2);
         KEY_P0_STA, KEY_P0_STB: h = key_hit(2'd0, BTN_START);
         KEY_P0_COIN:            h = key_hit(2'd0, BTN_COIN);
         KEY_P1_U:               h = key_hit(2'd1, BTN_U);
         KEY_P1_D:               h = key_hit(2'd1, BTN_D);
         KEY_P1_L:               h = key_hit(2'd1, BTN_L);
         KEY_P1_R:               h = key_hit(2'd1, BTN_R);
         KEY_P1_F1:              h = key_hit(2'd1, BTN_F1);
         KEY_P1_F2:              h = key_hit(2'd1, BTN_F2);
         KEY_P1_STA, KEY_P1_STB: h = key_hit(2'd1, BTN_START);
         KEY_P1_COIN:            h = key_hit(2'd1, BTN_COIN);
         KEY_P2_U:               h = key_hit(2'd2, BTN_U);
         KEY_P2_D:               h = key_hit(2'd2, BTN_D);
         KEY_P2_L:               h = key_hit(2'd2, BTN_L);
         KEY_P2_R:               h = key_hit(2'd2, BTN_R);
         KEY_P2_F1:              h = key_hit(2'd2, BTN_F1);
         KEY_P2_F2:              h = key_hit(2'd2, BTN_F2);
         KEY_P2_ST:              h = key_hit(2'd2, BTN_START);
         KEY_P2_COIN:            h = key_hit(2'd2, BTN_COIN);
         KEY_P3_U:               h = key_hit(2'd3, BTN_U);
         KEY_P3_D:               h = key_hit(2'd3, BTN_D);
         KEY_P3_L:               h = key_hit(2'd3, BTN_L);
         KEY_P3_R:               h = key_hit(2'd3, BTN_R);
         KEY_P3_F1:              h = key_hit(2'd3, BTN_F1);
         KEY_P3_F2:              h = key_hit(2'd3, BTN_F2);
         KEY_P3_ST:              h = key_hit(2'd3, BTN_START);
         KEY_P3_COIN:            h = key_hit(2'd3, BTN_COIN);
         KEY_TEST:               h.test = 1'b1;
         default:                h = '0;
      endcase
      // Arrow keys arrive with or without the E0 prefix, so bit 8 is ignored
      if (code[7:0] == KEY_P0_U[7:0]) h = key_hit(2'd0, BTN_U);
      if (code[7:0] == KEY_P0_D[7:0]) h = key_hit(2'd0, BTN_D);
      if (code[7:0] == KEY_P0_L[7:0]) h = key_hit(2'd0, BTN_L);
      if (code[7:0] == KEY_P0_R[7:0]) h = key_hit(2'd0, BTN_R);
      return h;
   endfunction

endpackage

// File: rtl/arcade_coin_stretch.sv
// rtl/arcade_coin_stretch.sv - per-player coin pulse stretcher
//
// Purpose : turns a raw coin level into a pulse at least COIN_PULSE_CYC
//           cycles long; a coin held longer than that passes through until
//           released. Output is registered, so it lines up with the other
//           registered button bits.
// Ports   : clk_sys  - system clock
//           reset    - synchronous active-high reset
//           coin_raw - merged raw coin level (key | joystick)
//           coin_out - stretched coin level
module arcade_coin_stretch
   import arcade_input_pkg::*;
#(
   parameter int COIN_PULSE_CYC = 1200000
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic coin_raw,
   output logic coin_out
);

   localparam int               CNT_W    = $clog2(COIN_PULSE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COIN_PULSE_CYC - 1);

   coin_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             coin_q, coin_d;
   logic             prev_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      coin_d  = coin_q;
      case (state_q)
         COIN_IDLE: begin
            if (coin_raw && !prev_q) begin
               state_d = COIN_HOLD;
               cnt_d   = CNT_LOAD;
               coin_d  = 1'b1;
            end else begin
               coin_d  = 1'b0;
            end
         end
         COIN_HOLD: begin
            // Counter reaches zero on the last cycle of the minimum pulse
            if (cnt_q == '0) begin
               if (coin_raw) begin
                  state_d = COIN_WAIT_REL;
                  coin_d  = 1'b1;
               end else begin
                  state_d = COIN_IDLE;
                  coin_d  = 1'b0;
               end
            end else begin
               cnt_d  = cnt_q - CNT_W'(1);
               coin_d = 1'b1;
            end
         end
         COIN_WAIT_REL: begin
            coin_d = coin_raw;
            if (!coin_raw) state_d = COIN_IDLE;
         end
         default: begin
            state_d = COIN_IDLE;
            coin_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= COIN_IDLE;
         cnt_q   <= '0;
         coin_q  <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         coin_q  <= coin_d;
         prev_q  <= coin_raw;
      end
   end

   assign coin_out = coin_q;

endmodule

// File: rtl/arcade_input_hub.sv
// rtl/arcade_input_hub.sv - PS/2 + joystick + DIP download front-end for arcade cores
//
// Purpose : merges PS/2 key events and per-player joystick words into
//           registered, direction-cleaned button vectors with stretched coin,
//           and captures DIP bytes from the MRA download stream.
// Build   : define INPUT_COMBO_COIN_EN to also derive coin from start+fire2.
// Ports   : clk_sys     - system clock
//           reset       - synchronous active-high reset (DIPs are kept)
//           ps2_key     - [10] toggle, [9] pressed, [8:0] scan code
//           joy         - per-player 16-bit joystick words
//           ioctl_wr / ioctl_index / ioctl_addr / ioctl_dout - download bus
//           btn_out     - per-player 8-bit active-high buttons
//           test        - service/test key state
//           dip         - DIP byte bank, byte n at [8n+7:8n]
//           dip_valid   - a DIP byte has been written since power-up
module arcade_input_hub
   import arcade_input_pkg::*;
#(
   parameter int PLAYERS        = 2,
   parameter int DIP_BYTES      = 8,
   parameter int DIP_INDEX      = 254,
   parameter int COIN_PULSE_CYC = 1200000
) (
   input  logic                   clk_sys,
   input  logic                   reset,
   input  logic [10:0]            ps2_key,
   input  logic [PLAYERS*16-1:0]  joy,
   input  logic                   ioctl_wr,
   input  logic [7:0]             ioctl_index,
   input  logic [24:0]            ioctl_addr,
   input  logic [7:0]             ioctl_dout,
   output logic [PLAYERS*8-1:0]   btn_out,
   output logic                   test,
   output logic [DIP_BYTES*8-1:0] dip,
   output logic                   dip_valid
);

   logic                   toggle_q, toggle_d;
   logic                   key_event;
   key_hit_t               hit;
   logic [PLAYERS*8-1:0]   key_q, key_d;
   logic                   test_q, test_d;
   logic [PLAYERS*8-1:0]   btn_q, btn_d;
   logic [PLAYERS-1:0]     coin_raw;
   logic [PLAYERS-1:0]     coin_out;
   logic [7:0]             raw;
   logic [7:0]             clean;
`ifdef INPUT_COMBO_COIN_EN
   logic                   combo;
`endif
   logic [PLAYERS*8-1:0]   unused_joy_hi;

   // DIPs survive reset; they only take their power-up value once
   logic [DIP_BYTES*8-1:0] dip_q = {DIP_BYTES{8'hFF}};
   logic [DIP_BYTES*8-1:0] dip_d;
   logic                   dip_valid_q = 1'b0;
   logic                   dip_valid_d;
   logic                   dip_wr;

   // ------------------------------------------------------------------
   // Key events: one per toggle change of ps2_key[10]
   // ------------------------------------------------------------------
   always_comb begin
      toggle_d  = ps2_key[10];
      key_event = (toggle_q != ps2_key[10]);
      hit       = key_decode(ps2_key[8:0]);
   end

   always_comb begin
      key_d  = key_q;
      test_d = test_q;
      if (key_event) begin
         if (hit.test) test_d = ps2_key[9];
         for (int p = 0; p < PLAYERS; p++) begin
            if (hit.hit && (hit.player == 2'(p))) begin
               key_d[8*p + int'(hit.bit_idx)] = ps2_key[9];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Merge, combo coin and opposite-direction cleaning
   // ------------------------------------------------------------------
   always_comb begin
      btn_d    = '0;
      coin_raw = '0;
      raw      = '0;
      clean    = '0;
`ifdef INPUT_COMBO_COIN_EN
      combo    = 1'b0;
`endif
      for (int p = 0; p < PLAYERS; p++) begin
         raw = key_q[8*p +: 8] | joy[16*p +: 8];
`ifdef INPUT_COMBO_COIN_EN
         // Pads without a coin button insert coin with start+fire2; those
         // two buttons are hidden from the core while the combo is held
         combo       = raw[BTN_START] & raw[BTN_F2];
         coin_raw[p] = raw[BTN_COIN] | combo;
         if (combo) begin
            raw[BTN_START] = 1'b0;
            raw[BTN_F2]    = 1'b0;
         end
`else
         coin_raw[p] = raw[BTN_COIN];
`endif
         clean = raw;
         if (raw[BTN_L] && raw[BTN_R]) begin
            clean[BTN_L] = 1'b0;
            clean[BTN_R] = 1'b0;
         end
         if (raw[BTN_U] && raw[BTN_D]) begin
            clean[BTN_U] = 1'b0;
            clean[BTN_D] = 1'b0;
         end
         // Coin comes from the stretcher, which is registered on its own
         clean[BTN_COIN] = 1'b0;
         btn_d[8*p +: 8] = clean;
      end
   end

   always_comb begin
      unused_joy_hi = '0;
      for (int p = 0; p < PLAYERS; p++) begin
         unused_joy_hi[8*p +: 8] = joy[16*p + 8 +: 8];
      end
   end

   for (genvar p = 0; p < PLAYERS; p++) begin : g_coin
      arcade_coin_stretch #(
         .COIN_PULSE_CYC (COIN_PULSE_CYC)
      ) u_coin (
         .clk_sys  (clk_sys),
         .reset    (reset),
         .coin_raw (coin_raw[p]),
         .coin_out (coin_out[p])
      );
   end

   // ------------------------------------------------------------------
   // DIP capture from the download stream
   // ------------------------------------------------------------------
   always_comb begin
      dip_d       = dip_q;
      dip_valid_d = dip_valid_q;
      dip_wr      = ioctl_wr && (ioctl_index == 8'(DIP_INDEX)) &&
                    (ioctl_addr < 25'(DIP_BYTES));
      if (dip_wr) begin
         dip_valid_d = 1'b1;
         for (int n = 0; n < DIP_BYTES; n++) begin
            if (ioctl_addr == 25'(n)) dip_d[8*n +: 8] = ioctl_dout;
         end
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_sys) begin
      // Toggle tracks the bus even in reset so an event seen during reset
      // is consumed rather than replayed afterwards
      toggle_q    <= toggle_d;
      dip_q       <= dip_d;
      dip_valid_q <= dip_valid_d;
      if (reset) begin
         key_q  <= '0;
         test_q <= 1'b0;
         btn_q  <= '0;
      end else begin
         key_q  <= key_d;
         test_q <= test_d;
         btn_q  <= btn_d;
      end
   end

   always_comb begin
      btn_out = btn_q;
      for (int p = 0; p < PLAYERS; p++) begin
         btn_out[8*p + BTN_COIN] = coin_out[p];
      end
   end

   assign test      = test_q;
   assign dip       = dip_q;
   assign dip_valid = dip_valid_q;

endmodule

// File: tb/tb_arcade_input_hub.sv
// tb/tb_arcade_input_hub.sv - self-checking bench for arcade_input_hub
module tb_arcade_input_hub;

   localparam int NP = 2;
   localparam int ND = 8;
   localparam int NC = 8;

   // {arrow, code[8:0], player (7 = test key), bit}
   localparam logic [15:0] KMAP [36] = '{
      {1'b1, 9'h075, 3'd0, 3'd3}, {1'b1, 9'h072, 3'd0, 3'd2},
      {1'b1, 9'h06B, 3'd0, 3'd1}, {1'b1, 9'h074, 3'd0, 3'd0},
      {1'b0, 9'h029, 3'd0, 3'd4}, {1'b0, 9'h014, 3'd0, 3'd4},
      {1'b0, 9'h011, 3'd0, 3'd5}, {1'b0, 9'h016, 3'd0, 3'd6},
      {1'b0, 9'h005, 3'd0, 3'd6}, {1'b0, 9'h02E, 3'd0, 3'd7},
      {1'b0, 9'h02D, 3'd1, 3'd3}, {1'b0, 9'h02B, 3'd1, 3'd2},
      {1'b0, 9'h023, 3'd1, 3'd1}, {1'b0, 9'h034, 3'd1, 3'd0},
      {1'b0, 9'h01C, 3'd1, 3'd4}, {1'b0, 9'h01B, 3'd1, 3'd5},
      {1'b0, 9'h01E, 3'd1, 3'd6}, {1'b0, 9'h006, 3'd1, 3'd6},
      {1'b0, 9'h036, 3'd1, 3'd7},
      {1'b0, 9'h043, 3'd2, 3'd3}, {1'b0, 9'h042, 3'd2, 3'd2},
      {1'b0, 9'h03B, 3'd2, 3'd1}, {1'b0, 9'h04B, 3'd2, 3'd0},
      {1'b0, 9'h03A, 3'd2, 3'd4}, {1'b0, 9'h031, 3'd2, 3'd5},
      {1'b0, 9'h026, 3'd2, 3'd6}, {1'b0, 9'h03D, 3'd2, 3'd7},
      {1'b0, 9'h044, 3'd3, 3'd3}, {1'b0, 9'h04D, 3'd3, 3'd2},
      {1'b0, 9'h054, 3'd3, 3'd1}, {1'b0, 9'h05B, 3'd3, 3'd0},
      {1'b0, 9'h049, 3'd3, 3'd4}, {1'b0, 9'h041, 3'd3, 3'd5},
      {1'b0, 9'h025, 3'd3, 3'd6}, {1'b0, 9'h03E, 3'd3, 3'd7},
      {1'b0, 9'h02C, 3'd7, 3'd0}
   };

   logic            clk_sys = 1'b0;
   logic            reset;
   logic [10:0]     ps2_key;
   logic [NP*16-1:0] joy;
   logic            ioctl_wr;
   logic [7:0]      ioctl_index;
   logic [24:0]     ioctl_addr;
   logic [7:0]      ioctl_dout;
   logic [NP*8-1:0] btn_out;
   logic            test;
   logic [ND*8-1:0] dip;
   logic            dip_valid;

   int checks = 0;
   int errors = 0;

   arcade_input_hub #(
      .PLAYERS        (NP),
      .DIP_BYTES      (ND),
      .DIP_INDEX      (254),
      .COIN_PULSE_CYC (NC)
   ) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .ps2_key     (ps2_key),
      .joy         (joy),
      .ioctl_wr    (ioctl_wr),
      .ioctl_index (ioctl_index),
      .ioctl_addr  (ioctl_addr),
      .ioctl_dout  (ioctl_dout),
      .btn_out     (btn_out),
      .test        (test),
      .dip         (dip),
      .dip_valid   (dip_valid)
   );

   always #5 clk_sys = ~clk_sys;

   // ------------------------------------------------------------------
   // Behavioural model: latches per player, coin as "triggered at cycle t"
   // ------------------------------------------------------------------
   logic [7:0]      m_lat [NP];
   bit              m_test;
   bit              m_active [NP];
   int              m_start [NP];
   bit              m_prev [NP];
   logic [7:0]      m_dip [ND] = '{default: 8'hFF};
   bit              m_valid = 1'b0;
   bit              m_tog = 1'b0;
   int              m_t = 0;
   logic [7:0]      m_raw, m_o;
   bit              m_cin, m_c, m_found;
   logic [15:0]     m_e;
   int              m_pl, m_bt;
   logic [NP*8-1:0] exp_btn;
   logic            exp_test;
   logic [ND*8-1:0] exp_dip;
   logic            exp_valid;
   bit              started = 1'b0;

   always @(posedge clk_sys) begin
      m_t++;
      if (reset) begin
         for (int p = 0; p < NP; p++) begin
            m_lat[p] = 8'h00;
            m_active[p] = 1'b0;
            m_prev[p] = 1'b0;
         end
         m_test = 1'b0;
         exp_btn = '0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            m_raw = m_lat[p] | joy[16*p +: 8];
            m_cin = m_raw[7];
`ifdef INPUT_COMBO_COIN_EN
            if (m_raw[6] && m_raw[5]) begin
               m_cin = 1'b1;
               m_raw[6] = 1'b0;
               m_raw[5] = 1'b0;
            end
`endif
            m_o = m_raw & 8'h7F;
            if (m_o[0] && m_o[1]) m_o[1:0] = 2'b00;
            if (m_o[2] && m_o[3]) m_o[3:2] = 2'b00;
            if (!m_active[p] && m_cin && !m_prev[p]) begin
               m_active[p] = 1'b1;
               m_start[p] = m_t;
            end
            m_c = 1'b0;
            if (m_active[p]) begin
               if (m_t - m_start[p] < NC) m_c = 1'b1;
               else if (m_cin) m_c = 1'b1;
               else m_active[p] = 1'b0;
            end
            m_prev[p] = m_cin;
            m_o[7] = m_c;
            exp_btn[8*p +: 8] = m_o;
         end
         if (ps2_key[10] != m_tog) begin
            m_found = 1'b0;
            for (int i = 0; i < 36; i++) begin
               m_e = KMAP[i];
               if (!m_found && (m_e[15] ? (ps2_key[7:0] == m_e[13:6])
                                        : (ps2_key[8:0] == m_e[14:6]))) begin
                  m_found = 1'b1;
                  m_pl = int'(m_e[5:3]);
                  m_bt = int'(m_e[2:0]);
                  if (m_pl == 7) m_test = ps2_key[9];
                  else if (m_pl < NP) m_lat[m_pl][m_bt] = ps2_key[9];
               end
            end
         end
      end
      m_tog = ps2_key[10];
      if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'(ND)) begin
         m_dip[int'(ioctl_addr)] = ioctl_dout;
         m_valid = 1'b1;
      end
      exp_test = m_test;
      for (int n = 0; n < ND; n++) exp_dip[8*n +: 8] = m_dip[n];
      exp_valid = m_valid;
      started = 1'b1;
   end

   always @(negedge clk_sys) begin
      if (started) begin
         checks++;
         if (btn_out !== exp_btn) begin
            errors++;
            $display("FAIL model_btn t=%0t actual %h expected %h", $time, btn_out, exp_btn);
         end
         checks++;
         if (test !== exp_test) begin
            errors++;
            $display("FAIL model_test t=%0t actual %b expected %b", $time, test, exp_test);
         end
         checks++;
         if (dip !== exp_dip) begin
            errors++;
            $display("FAIL model_dip t=%0t actual %h expected %h", $time, dip, exp_dip);
         end
         checks++;
         if (dip_valid !== exp_valid) begin
            errors++;
            $display("FAIL model_dip_valid t=%0t actual %b expected %b", $time, dip_valid, exp_valid);
         end
      end
   end

   // ------------------------------------------------------------------
   // Directed stimulus with literal expectations
   // ------------------------------------------------------------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_sys);
   endtask

   task automatic key(input logic [8:0] code, input logic pressed);
      ps2_key = {~ps2_key[10], pressed, code};
   endtask

   task automatic dip_write(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
      ioctl_wr    = 1'b1;
      ioctl_index = idx;
      ioctl_addr  = addr;
      ioctl_dout  = data;
      step();
      ioctl_wr    = 1'b0;
   endtask

   int cnt, first, last;

   initial begin
      reset = 1'b1;
      ps2_key = '0;
      joy = '0;
      ioctl_wr = 1'b0;
      ioctl_index = 8'd0;
      ioctl_addr = '0;
      ioctl_dout = 8'd0;
      repeat (3) step();
      chk("rst_btn", 64'(btn_out), 64'h0);
      chk("rst_test", 64'(test), 64'h0);
      chk("rst_dip", dip, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("rst_dip_valid", 64'(dip_valid), 64'h0);
      reset = 1'b0;
      step();

      // one-cycle coin pulse, second pulse inside the hold window
      cnt = 0; first = -1;
      for (int i = 0; i < 16; i++) begin
         joy[7] = (i == 0 || i == 3);
         step();
         if (btn_out[7]) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      chk("coin_pulse_len", 64'(cnt), 64'd8);
      chk("coin_pulse_first", 64'(first), 64'd0);

      // coin held 20 cycles
      cnt = 0; last = -1;
      for (int i = 0; i < 30; i++) begin
         joy[7] = (i < 20);
         step();
         if (btn_out[7]) begin
            cnt++;
            last = i;
         end
      end
      chk("coin_hold_len", 64'(cnt), 64'd20);
      chk("coin_hold_last", 64'(last), 64'd19);
      joy = '0;

      // extended left arrow, then L+R cleaning, then release
      key(9'h16B, 1'b1);
      step();
      chk("key_lat_1cyc", 64'(btn_out[1]), 64'h0);
      step();
      chk("key_lat_2cyc", 64'(btn_out[1]), 64'h1);
      joy[0] = 1'b1;
      step();
      chk("clean_lr", 64'(btn_out[1:0]), 64'h0);
      key(9'h16B, 1'b0);
      step(); step();
      chk("release_l", 64'(btn_out[1:0]), 64'h1);
      joy = '0;
      step();

      // player 2 code with two players, then player 1 start
      key(9'h043, 1'b1);
      step(); step();
      chk("p2_ignored", 64'(btn_out), 64'h0);
      key(9'h043, 1'b0);
      step();
      key(9'h01E, 1'b1);
      step(); step();
      chk("p1_start", 64'(btn_out[14]), 64'h1);

      // test key
      key(9'h02C, 1'b1);
      step();
      chk("test_on", 64'(test), 64'h1);
      key(9'h02C, 1'b0);
      step();
      chk("test_off", 64'(test), 64'h0);

      // up + down cleaning with non-extended arrows
      key(9'h075, 1'b1);
      step();
      key(9'h072, 1'b1);
      step(); step();
      chk("clean_ud", 64'(btn_out[3:2]), 64'h0);
      key(9'h075, 1'b0);
      step(); step();
      chk("down_only", 64'(btn_out[3:2]), 64'h1);
      key(9'h072, 1'b0);
      step();

      // extended variant of a non-arrow code is not a match
      key(9'h114, 1'b1);
      step(); step();
      chk("ext_f1_ignored", 64'(btn_out[4]), 64'h0);
      key(9'h114, 1'b0);
      step();

      // DIP capture
      dip_write(8'd254, 25'd2, 8'hA5);
      chk("dip_byte2", 64'(dip[23:16]), 64'hA5);
      chk("dip_valid_set", 64'(dip_valid), 64'h1);
      dip_write(8'd254, 25'd9, 8'h11);
      chk("dip_addr9", dip, 64'hFFFF_FFFF_FFA5_FFFF);
      dip_write(8'd254, 25'd8, 8'h22);
      chk("dip_addr8", dip, 64'hFFFF_FFFF_FFA5_FFFF);
      dip_write(8'd253, 25'd0, 8'h33);
      chk("dip_wrong_index", dip, 64'hFFFF_FFFF_FFA5_FFFF);
      dip_write(8'd254, 25'd7, 8'h3C);
      chk("dip_byte7", 64'(dip[63:56]), 64'h3C);

      // key event and DIP write in the same cycle
      key(9'h01C, 1'b1);
      dip_write(8'd254, 25'd0, 8'h5A);
      step();
      chk("simul_key", 64'(btn_out[12]), 64'h1);
      chk("simul_dip", 64'(dip[7:0]), 64'h5A);

      // reset with keys held and a key event in the first reset cycle
      reset = 1'b1;
      key(9'h023, 1'b1);
      step(); step();
      chk("rst2_btn", 64'(btn_out), 64'h0);
      chk("rst2_dip", dip, 64'h3CFF_FFFF_FFA5_FF5A);
      chk("rst2_dip_valid", 64'(dip_valid), 64'h1);
      reset = 1'b0;
      step(); step();
      chk("held_after_rst", 64'(btn_out), 64'h0);

      // start + fire2 on player 1 joystick
      joy[22] = 1'b1;
      joy[21] = 1'b1;
      step();
`ifdef INPUT_COMBO_COIN_EN
      chk("combo_start", 64'(btn_out[14]), 64'h0);
      chk("combo_fire2", 64'(btn_out[13]), 64'h0);
      chk("combo_coin", 64'(btn_out[15]), 64'h1);
`else
      chk("combo_start", 64'(btn_out[14]), 64'h1);
      chk("combo_fire2", 64'(btn_out[13]), 64'h1);
      chk("combo_coin", 64'(btn_out[15]), 64'h0);
`endif
      joy = '0;
      repeat (12) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached at %0t", $time);
      $fatal(1);
   end

endmodule
